// File: rtl/lpc_capture_ctrl.sv
// lpc_capture_ctrl: LPC address-window decode, cycle-word qualify, FIFO capture and stream drain
// Ports:
//   clk_i, nrst_i             clock (rising edge), asynchronous active-low reset
//   cfg_en_i/base_i/mask_i    capture enable, address window base and compare mask
//   lpc_addr_i, addr_hit_o    peripheral address in, combinational window hit out
//   tdata_i, ready_i          cycle word and its strobe (one word per rising edge)
//   flush_i                   synchronous discard of all queued words
//   m_tdata_o/tvalid_o/tready_i  downstream valid/ready stream
//   fifo_level_o              words held, including the presented word
//   overflow_cnt_o            saturating count of words dropped while full
// Option: define LPC_CAPTURE_SEQ_EN to stamp a 4-bit sequence number into word bits [31:28].
module lpc_capture_ctrl #(
  parameter int DEPTH = 8,
  parameter int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          cfg_en_i,
  input  logic [15:0]   cfg_base_i,
  input  logic [15:0]   cfg_mask_i,
  input  logic [15:0]   lpc_addr_i,
  output logic          addr_hit_o,
  input  logic [31:0]   tdata_i,
  input  logic          ready_i,
  input  logic          flush_i,
  output logic [31:0]   m_tdata_o,
  output logic          m_tvalid_o,
  input  logic          m_tready_i,
  output logic [LW-1:0] fifo_level_o,
  output logic [15:0]   overflow_cnt_o
);
  localparam int AW = LW - 1;
  typedef enum logic [1:0] {IDLE, VALID, FLUSH} state_t;
  state_t state, state_nxt;
  logic ready_q;
  logic [LW-1:0] wr_ptr, rd_ptr, level, hptr;
  logic [31:0] mem [DEPTH];
  logic [31:0] word, head_nxt;
  logic cand, qual, clr, acc, full, pop, push, drop, more, load;
`ifdef LPC_CAPTURE_SEQ_EN
  logic [3:0] seq;
`endif
  assign addr_hit_o = cfg_en_i & ((lpc_addr_i & cfg_mask_i) == (cfg_base_i & cfg_mask_i));
  assign m_tvalid_o = state == VALID;
  assign fifo_level_o = level;
  always_comb begin
    level = wr_ptr - rd_ptr;
    full = level == LW'(DEPTH);
    cand = ready_i & ~ready_q;
    // type 01 and 11 are exactly the codes with bit 0 set
    qual = cfg_en_i & tdata_i[0] & ((tdata_i[27:12] & cfg_mask_i) == (cfg_base_i & cfg_mask_i));
    // candidates are discarded both on the flush edge and during the FLUSH clock
    clr = flush_i | (state == FLUSH);
    acc = cand & qual & ~clr;
    pop = (state == VALID) & m_tready_i & ~flush_i;
    push = acc & (~full | pop);
    drop = acc & full & ~pop;
    more = (level != LW'(1)) | push;
`ifdef LPC_CAPTURE_SEQ_EN
    word = {seq, tdata_i[27:0]};
`else
    word = tdata_i;
`endif
    // next head is the word after the popped one; bypass when it is being written this edge
    hptr = (state == VALID) ? rd_ptr + LW'(1) : rd_ptr;
    head_nxt = (push && wr_ptr == hptr) ? word : mem[hptr[AW-1:0]];
    load = ((state == IDLE) & ~flush_i & (level != '0)) | (pop & more);
    state_nxt = flush_i ? FLUSH :
                (state == FLUSH) ? IDLE :
                (state == IDLE) ? ((level != '0) ? VALID : IDLE) :
                (pop & ~more) ? IDLE : VALID;
  end
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state <= IDLE;
      ready_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      m_tdata_o <= '0;
      overflow_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      ready_q <= ready_i;
      if (push) wr_ptr <= wr_ptr + LW'(1);
      rd_ptr <= clr ? wr_ptr : pop ? rd_ptr + LW'(1) : rd_ptr;
      if (load) m_tdata_o <= head_nxt;
      if (drop && overflow_cnt_o != 16'hFFFF) overflow_cnt_o <= overflow_cnt_o + 16'd1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= word;
  end
`ifdef LPC_CAPTURE_SEQ_EN
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) seq <= 4'd0;
    else if (push) seq <= seq + 4'd1;
  end
`endif
endmodule

// File: tb/tb_lpc_capture_ctrl.sv
// tb_lpc_capture_ctrl: directed and randomized checks of lpc_capture_ctrl against a queue model
module tb_lpc_capture_ctrl;
  localparam int DEPTH = 8;
  localparam int LW = 4;
  logic clk_i = 0, nrst_i = 0, cfg_en_i = 0;
  logic [15:0] cfg_base_i = 0, cfg_mask_i = 0, lpc_addr_i = 0;
  logic addr_hit_o;
  logic [31:0] tdata_i = 0;
  logic ready_i = 0, flush_i = 0;
  logic [31:0] m_tdata_o;
  logic m_tvalid_o, m_tready_i = 0;
  logic [LW-1:0] fifo_level_o;
  logic [15:0] overflow_cnt_o;
  int checks = 0, errors = 0;
  logic [31:0] q[$];
  int m_ovf = 0;
  bit m_vld = 0, m_rq = 0, m_fl = 0;
  bit [3:0] m_seq = 0;

  lpc_capture_ctrl #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk_i(clk_i), .nrst_i(nrst_i), .cfg_en_i(cfg_en_i), .cfg_base_i(cfg_base_i),
    .cfg_mask_i(cfg_mask_i), .lpc_addr_i(lpc_addr_i), .addr_hit_o(addr_hit_o),
    .tdata_i(tdata_i), .ready_i(ready_i), .flush_i(flush_i), .m_tdata_o(m_tdata_o),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .fifo_level_o(fifo_level_o),
    .overflow_cnt_o(overflow_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stored(input logic [31:0] w, input bit [3:0] s);
`ifdef LPC_CAPTURE_SEQ_EN
    return {s, w[27:0]};
`else
    return w + 32'(s & 4'd0);
`endif
  endfunction

  function automatic logic [31:0] rword(input bit good);
    logic [15:0] a = good ? (16'h0080 | 16'($urandom_range(0, 7))) : 16'($urandom);
    logic [1:0] t = good ? {1'($urandom), 1'b1} : 2'($urandom);
    return {4'($urandom), a, 8'($urandom), 2'($urandom), t};
  endfunction

  task automatic model_edge();
    bit cand, acc, pop;
    int sz;
    if (!nrst_i) begin
      q.delete(); m_ovf = 0; m_vld = 0; m_rq = 0; m_fl = 0; m_seq = 0;
      return;
    end
    cand = ready_i && !m_rq;
    acc = cand && cfg_en_i && (tdata_i[1:0] inside {2'b01, 2'b11}) &&
          ((tdata_i[27:12] & cfg_mask_i) == (cfg_base_i & cfg_mask_i)) && !flush_i && !m_fl;
    pop = m_vld && m_tready_i && !flush_i;
    sz = q.size();
    m_rq = ready_i;
    if (flush_i) begin
      q.delete();
      m_vld = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        if (q.size() < DEPTH) begin
          q.push_back(stored(tdata_i, m_seq));
          m_seq++;
        end else if (m_ovf < 65535) m_ovf++;
      end
      m_vld = m_vld ? (q.size() != 0) : (sz != 0);
    end
    m_fl = flush_i;
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_edge();
    #1;
    chk("valid", 32'(m_tvalid_o), 32'(m_vld));
    chk("level", 32'(fifo_level_o), 32'(q.size()));
    chk("overflow", 32'(overflow_cnt_o), 32'(m_ovf));
    if (m_vld) chk("data", m_tdata_o, q[0]);
  endtask

  task automatic pulse(input logic [31:0] w);
    tdata_i = w;
    ready_i = 1;
    cycle();
    if ($urandom_range(0, 1) == 1) cycle();
    ready_i = 0;
    cycle();
  endtask

  logic [31:0] exp_w [10];
  logic [31:0] w;
  bit [3:0] sb;
  logic [15:0] ovf_keep;

  initial begin
    cfg_base_i = 16'h0080; cfg_mask_i = 16'hFFF8; cfg_en_i = 1; lpc_addr_i = 16'h0084;
    #1 chk("hit_in_reset", 32'(addr_hit_o), 1);
    repeat (2) cycle();
    chk("rst_tdata", m_tdata_o, 0);
    nrst_i = 1;
    lpc_addr_i = 16'h0090;
    #1 chk("hit_outside", 32'(addr_hit_o), 0);
    cfg_en_i = 0; lpc_addr_i = 16'h0084;
    #1 chk("hit_disabled", 32'(addr_hit_o), 0);
    cfg_en_i = 1;
    #1 chk("hit_inside", 32'(addr_hit_o), 1);

    m_tready_i = 1; tdata_i = 32'h0008_4A51; ready_i = 1;
    cycle();
    chk("cap_level", 32'(fifo_level_o), 1);
    chk("cap_valid_e", 32'(m_tvalid_o), 0);
    cycle();
    ready_i = 0;
    chk("cap_valid_e1", 32'(m_tvalid_o), 1);
    chk("cap_data", m_tdata_o, 32'h0008_4A51);
    cycle();
    chk("cap_valid_e2", 32'(m_tvalid_o), 0);
    chk("cap_level_e2", 32'(fifo_level_o), 0);

    pulse(32'h0008_4A50);
    pulse(32'h0010_0A51);
    chk("qual_level", 32'(fifo_level_o), 0);
    chk("qual_ovf", 32'(overflow_cnt_o), 0);

    m_tready_i = 0;
    sb = m_seq;
    for (int i = 0; i < 10; i++) begin
      w = rword(1);
      exp_w[i] = stored(w, sb + 4'(i));
      pulse(w);
    end
    chk("bp_level", 32'(fifo_level_o), 8);
    chk("bp_ovf", 32'(overflow_cnt_o), 2);
    m_tready_i = 1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(m_tvalid_o), 1);
      chk("drain_data", m_tdata_o, exp_w[i]);
      cycle();
    end
    chk("drain_done_valid", 32'(m_tvalid_o), 0);
    chk("drain_done_level", 32'(fifo_level_o), 0);

    m_tready_i = 0;
    for (int i = 0; i < 8; i++) pulse(rword(1));
    chk("fpp_full", 32'(fifo_level_o), 8);
    m_tready_i = 1; tdata_i = rword(1); ready_i = 1;
    cycle();
    chk("fpp_level", 32'(fifo_level_o), 8);
    chk("fpp_ovf", 32'(overflow_cnt_o), 2);
    ready_i = 0;
    repeat (10) cycle();
    chk("fpp_empty", 32'(fifo_level_o), 0);

    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 120; i++) begin
        ready_i = $urandom_range(0, 2) != 0;
        tdata_i = rword($urandom_range(0, 4) != 0);
        m_tready_i = $urandom_range(0, p) == 0;
        flush_i = !flush_i && $urandom_range(0, 40) == 0;
        if ($urandom_range(0, 60) == 0) cfg_en_i = !cfg_en_i;
        cycle();
      end
    end
    flush_i = 0; cfg_en_i = 1; ready_i = 0; m_tready_i = 0;
    cycle();

    flush_i = 1;
    cycle();
    flush_i = 0;
    cycle();
    for (int i = 0; i < 3; i++) pulse(rword(1));
    chk("fl_queued", 32'(fifo_level_o), 3);
    ovf_keep = overflow_cnt_o;
    flush_i = 1;
    cycle();
    flush_i = 0;
    chk("fl_valid", 32'(m_tvalid_o), 0);
    chk("fl_level", 32'(fifo_level_o), 0);
    cycle();
    chk("fl_ovf_kept", 32'(overflow_cnt_o), 32'(ovf_keep));

    for (int i = 0; i < 3; i++) pulse(rword(1));
    m_tready_i = 1;
    cycle();
    chk("md_valid", 32'(m_tvalid_o), 1);
    #2 nrst_i = 0;
    #1;
    chk("md_rst_valid", 32'(m_tvalid_o), 0);
    chk("md_rst_tdata", m_tdata_o, 0);
    chk("md_rst_level", 32'(fifo_level_o), 0);
    chk("md_rst_ovf", 32'(overflow_cnt_o), 0);
    cycle();
    nrst_i = 1;
    pulse(32'h0008_4A51);
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lpc_capture_ctrl.md
# lpc_capture_ctrl

Capture controller for the LPC peripheral front end. It decodes the peripheral's address-hit window and qualifies each completed cycle word (32-bit TDATA with a READY pulse). Accepted words are buffered in a FIFO and drained to a downstream consumer over a valid/ready stream. It also counts dropped words and supports a synchronous flush.

## Interface
Parameters:
- DEPTH, 8, FIFO depth in words; power of two, 2..64.
- LW, $clog2(DEPTH)+1, width of the level output.

Ports:
- clk_i  input  1  LPC clock; all logic on the rising edge.
- nrst_i  input  1  reset; asynchronous, active-low.
- cfg_en_i  input  1  capture/decode enable.
- cfg_base_i  input  16  address window base.
- cfg_mask_i  input  16  address compare mask; 1 means the bit is compared.
- lpc_addr_i  input  16  current LPC address from the peripheral.
- addr_hit_o  output  1  address hit to the peripheral; combinational.
- tdata_i  input  32  cycle word: [27:12] address, [11:4] data, [1:0] type (01 write, 11 read).
- ready_i  input  1  word-valid strobe from the peripheral; held high 1–2 clocks per word.
- flush_i  input  1  synchronous FIFO discard.
- m_tdata_o  output  32  stream data.
- m_tvalid_o  output  1  stream valid.
- m_tready_i  input  1  stream ready.
- fifo_level_o  output  LW  words held, including the output word.
- overflow_cnt_o  output  16  dropped-word count; saturates at 16'hFFFF.

## Operation
- addr_hit_o = cfg_en_i & ((lpc_addr_i & cfg_mask_i) == (cfg_base_i & cfg_mask_i)).
- Edge detect: ready_q <= ready_i. A push candidate exists when ready_i & ~ready_q.
  - A strobe held high for 2 clocks produces one candidate.
  - Each new rising edge produces a new candidate.
- Qualify: a candidate is accepted only when all three hold:
  - cfg_en_i = 1,
  - tdata_i[1:0] ∈ {01, 11},
  - tdata_i[27:12] is inside the window under the same mask compare.
  - Unqualified candidates are silently ignored and are not counted as overflow.
- Storage: circular FIFO of DEPTH words.
  - Read and write pointers are LW bits wide; wrap-around is natural modulo 2·DEPTH.
  - level = wr_ptr − rd_ptr.
  - Full when level == DEPTH; empty when level == 0.
- Drain FSM states:
  - IDLE: m_tvalid_o = 0.
    - IDLE→VALID when level ≠ 0 and flush_i = 0.
    - In VALID, m_tdata_o presents the head word.
  - VALID: m_tvalid_o = 1; m_tdata_o must stay stable until the handshake.
    - Handshake (m_tvalid_o & m_tready_i) pops one word.
    - After a pop, stay in VALID if words remain, else go to IDLE.
    - VALID→FLUSH on flush_i.
  - FLUSH: one clock.
    - Pointers are set equal (rd_ptr <= wr_ptr); m_tvalid_o = 0.
    - A push candidate in this clock is discarded.
    - Then go to IDLE.
  - flush_i in IDLE also passes through FLUSH.
- Simultaneous push and pop:
  - When full, a push accompanied by a pop in the same clock is accepted; level is unchanged.
  - When empty, a push never pops in the same clock.
- Overflow: an accepted candidate while full without a pop is dropped and overflow_cnt_o increments (saturating).
  - overflow_cnt_o clears only on reset; flush does not clear it.
- cfg_* changes take effect the next clock. Words already queued are unaffected.

## Timing
- Reset values: m_tvalid_o = 0, m_tdata_o = 0, fifo_level_o = 0, overflow_cnt_o = 0, FSM = IDLE, ready_q = 0, pointers = 0.
  - addr_hit_o follows its inputs, including during reset.
- Push: the word is written at edge E, where ready_i = 1 and ready_q = 0 are sampled. fifo_level_o reflects it after E.
- Into an empty FIFO, m_tvalid_o rises after edge E+1 (1-clock latency). The head is registered.
- Throughput: one pop per clock while m_tready_i = 1. Back-to-back words stream without bubbles.
- Flush: after the edge sampling flush_i = 1, m_tvalid_o = 0 and fifo_level_o = 0.
- Reset mid-operation: everything returns to reset values immediately. Queued words are lost.

## Configuration
- LPC_CAPTURE_SEQ_EN defined:
  - A 4-bit sequence counter increments on each accepted, non-dropped word and wraps 15→0.
  - Its pre-increment value replaces bits [31:28] of the stored word.
  - The counter resets to 0 on nrst_i and is not affected by flush.
- LPC_CAPTURE_SEQ_EN undefined: bits [31:28] are stored exactly as received on tdata_i.

## Test plan
- Window decode: base=16'h0080, mask=16'hFFF8, cfg_en_i=1.
  - lpc_addr_i=16'h0084 → addr_hit_o=1; 16'h0090 → 0; cfg_en_i=0 → 0.
- Single capture: ready_i high 2 clocks with tdata_i=32'h0008_4A51 and m_tready_i=1.
  - One word is captured; m_tvalid_o high for 1 clock, 2 clocks after the strobe rise; m_tdata_o=32'h0008_4A51.
  - Sequence macro on: top nibble is 0.
- Qualification: type bits 2'b00, or address 16'h0100 outside the window.
  - No push; fifo_level_o stays 0; overflow_cnt_o stays 0.
- Backpressure and overflow: m_tready_i=0, DEPTH=8, 10 qualified words.
  - fifo_level_o=8; overflow_cnt_o=2.
  - With m_tready_i=1, exactly the first 8 words emerge in order, one per clock.
- Full with simultaneous push/pop: FIFO full, push edge and handshake in the same clock.
  - Level stays 8; overflow_cnt_o unchanged.
- Flush and reset: 3 words queued, then flush_i pulsed → m_tvalid_o=0 and level=0 next clock.
  - nrst_i asserted mid-drain → all outputs reach reset values asynchronously.
